mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM controller arbitrating an instruction-fetch port and a load/store port
// Optional one-entry fetch buffer enabled with `define MEM_CTRL_IBUF_EN
module mem_ctrl (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_done_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [1:0]  mem_size_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_done_o,
    output logic [31:0] ram_a_o,
    output logic [7:0]  ram_dout_o,
    input  logic [7:0]  ram_din_i,
    output logic        ram_wr_o,
    output logic        if_stall_req_o,
    output logic        mem_stall_req_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  last_q, last_d;
    logic [1:0]  cap_lane_q, cap_lane_d;
    logic [31:0] base_q, base_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        tag_mem_q, tag_mem_d;
    logic        drain_q, drain_d;
    logic        cap_vld_q, cap_vld_d;
    logic        if_done_q, if_done_d;
    logic        mem_done_q, mem_done_d;
    logic [31:0] rd_word;
    logic        fetch_hit;
    logic [31:0] hit_data;

    function automatic logic [1:0] size_last(input logic [1:0] size);
        case (size)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

`ifdef MEM_CTRL_IBUF_EN
    logic        ibuf_vld_q;
    logic [29:0] ibuf_tag_q;
    logic [31:0] ibuf_data_q;
    logic        fetch_fill;
    logic        store_inval;

    assign fetch_hit   = ibuf_vld_q && (ibuf_tag_q == if_addr_i[31:2]);
    assign hit_data    = ibuf_data_q;
    assign fetch_fill  = (state_q == READ) && drain_q && !tag_mem_q;
    assign store_inval = (state_q == IDLE) && mem_req_i && !mem_done_q && mem_we_i
                         && (mem_addr_i[31:2] == ibuf_tag_q);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ibuf_vld_q  <= 1'b0;
            ibuf_tag_q  <= '0;
            ibuf_data_q <= '0;
        end else if (fetch_fill) begin
            ibuf_vld_q  <= 1'b1;
            ibuf_tag_q  <= base_q[31:2];
            ibuf_data_q <= rd_word;
        end else if (store_inval) begin
            ibuf_vld_q  <= 1'b0;
        end
    end
`else
    assign fetch_hit = 1'b0;
    assign hit_data  = '0;
`endif

    assign if_stall_req_o  = if_req_i & ~if_done_q;
    assign mem_stall_req_o = mem_req_i & ~mem_done_q;
    assign if_data_o       = if_data_q;
    assign if_done_o       = if_done_q;
    assign mem_rdata_o     = mem_rdata_q;
    assign mem_done_o      = mem_done_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        tag_mem_d   = tag_mem_q;
        drain_d     = drain_q;
        cap_lane_d  = cap_lane_q;
        cap_vld_d   = 1'b0;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        ram_a_o     = '0;
        ram_dout_o  = '0;
        ram_wr_o    = 1'b0;

        // The byte addressed in the previous cycle arrives now; merge it into its lane
        rd_word = rbuf_q;
        if (cap_vld_q) begin
            rd_word[{cap_lane_q, 3'b000} +: 8] = ram_din_i;
        end
        rbuf_d = rd_word;

        case (state_q)
            IDLE: begin
                if (mem_req_i && !mem_done_q) begin
                    base_d    = mem_addr_i;
                    wdata_d   = mem_wdata_i;
                    last_d    = size_last(mem_size_i);
                    tag_mem_d = 1'b1;
                    cnt_d     = 2'd0;
                    drain_d   = 1'b0;
                    rbuf_d    = '0;
                    state_d   = mem_we_i ? WRITE : READ;
                end else if (if_req_i && !if_done_q) begin
                    if (fetch_hit) begin
                        if_done_d = 1'b1;
                        if_data_d = hit_data;
                    end else begin
                        base_d    = if_addr_i;
                        last_d    = 2'd3;
                        tag_mem_d = 1'b0;
                        cnt_d     = 2'd0;
                        drain_d   = 1'b0;
                        rbuf_d    = '0;
                        state_d   = READ;
                    end
                end
            end
            READ: begin
                if (!drain_q) begin
                    ram_a_o    = base_q + {30'd0, cnt_q};
                    cap_vld_d  = 1'b1;
                    cap_lane_d = cnt_q;
                    if (cnt_q == last_q) begin
                        drain_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end else begin
                    // Last byte lands this cycle; publish the word and free the bus
                    state_d = IDLE;
                    drain_d = 1'b0;
                    cnt_d   = 2'd0;
                    if (tag_mem_q) begin
                        mem_done_d  = 1'b1;
                        mem_rdata_d = rd_word;
                    end else begin
                        if_done_d = 1'b1;
                        if_data_d = rd_word;
                    end
                end
            end
            WRITE: begin
                ram_a_o    = base_q + {30'd0, cnt_q};
                ram_dout_o = wdata_q[{cnt_q, 3'b000} +: 8];
                ram_wr_o   = 1'b1;
                if (cnt_q == last_q) begin
                    state_d    = IDLE;
                    cnt_d      = 2'd0;
                    mem_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 2'd0;
                drain_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= '0;
            base_q      <= '0;
            wdata_q     <= '0;
            rbuf_q      <= '0;
            tag_mem_q   <= 1'b0;
            drain_q     <= 1'b0;
            cap_vld_q   <= 1'b0;
            cap_lane_q  <= '0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            rbuf_q      <= rbuf_d;
            tag_mem_q   <= tag_mem_d;
            drain_q     <= drain_d;
            cap_vld_q   <= cap_vld_d;
            cap_lane_q  <= cap_lane_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - randomized self-checking bench for mem_ctrl against a transaction-level memory model
module tb_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_done;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic [31:0] ram_a;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;
    logic        ram_wr;
    logic        if_stall;
    logic        mem_stall;

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data), .if_done_o(if_done),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_size_i(mem_size), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata), .mem_done_o(mem_done),
        .ram_a_o(ram_a), .ram_dout_o(ram_dout), .ram_din_i(ram_din), .ram_wr_o(ram_wr),
        .if_stall_req_o(if_stall), .mem_stall_req_o(mem_stall)
    );

`ifdef MEM_CTRL_IBUF_EN
    localparam bit IBUF = 1'b1;
`else
    localparam bit IBUF = 1'b0;
`endif

    logic [7:0]  ram     [bit [31:0]];
    logic [7:0]  ref_mem [bit [31:0]];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        ib_v     = 1'b0;
    logic [29:0] ib_tag   = '0;
    logic [31:0] ib_data  = '0;
    logic [31:0] last_if  = '0;
    logic [31:0] last_rd  = '0;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    // Byte-wide synchronous RAM: read data valid one cycle after the address
    always @(posedge clk) begin
        if (ram_wr === 1'b1) ram[ram_a] = ram_dout;
        ram_din <= ram_rd(ram_a);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_byte(input logic [31:0] a, input logic [7:0] v);
        ram[a]     = v;
        ref_mem[a] = v;
    endtask

    task automatic do_fetch(input logic [31:0] addr);
        logic        hit;
        int          lat;
        int          got;
        logic [31:0] exp;
        hit = IBUF && ib_v && (ib_tag == addr[31:2]);
        lat = hit ? 1 : 6;
        exp = hit ? ib_data : {ref_rd(addr + 3), ref_rd(addr + 2), ref_rd(addr + 1), ref_rd(addr)};
        @(posedge clk); @(negedge clk);
        if_req  = 1'b1;
        if_addr = addr;
        got = 0;
        for (int c = 1; c <= 20 && got == 0; c++) begin
            @(posedge clk); #1;
            if (!hit && c <= 4) begin
                check("fetch_addr", ram_a, addr + c - 1);
                check("fetch_wr", {31'd0, ram_wr}, 32'd0);
            end
            if (if_done) begin
                got = c;
                check("fetch_stall_done", {31'd0, if_stall}, 32'd0);
                check("fetch_idle_addr", ram_a, 32'd0);
                if_req = 1'b0;
            end else begin
                check("fetch_stall", {31'd0, if_stall}, 32'd1);
            end
        end
        if_req = 1'b0;
        check("fetch_lat", got, lat);
        check("fetch_data", if_data, exp);
        check("fetch_rd_hold", mem_rdata, last_rd);
        last_if = exp;
        ib_v    = 1'b1;
        ib_tag  = addr[31:2];
        ib_data = exp;
    endtask

    task automatic do_mem(input logic we, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata);
        int          n;
        int          lat;
        int          got;
        logic [31:0] exp;
        n   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        lat = we ? n + 1 : n + 2;
        exp = '0;
        for (int i = 0; i < n; i++) exp |= {24'd0, ref_rd(addr + i)} << (8 * i);
        if (we) begin
            for (int i = 0; i < n; i++) ref_mem[addr + i] = 8'((wdata >> (8 * i)) & 32'hFF);
            if (addr[31:2] == ib_tag) ib_v = 1'b0;
            exp = last_rd;
        end
        @(posedge clk); @(negedge clk);
        mem_req   = 1'b1;
        mem_we    = we;
        mem_size  = size;
        mem_addr  = addr;
        mem_wdata = wdata;
        got = 0;
        for (int c = 1; c <= 20 && got == 0; c++) begin
            @(posedge clk); #1;
            if (c <= n) begin
                check("mem_addr", ram_a, addr + c - 1);
                check("mem_wr", {31'd0, ram_wr}, {31'd0, we});
                if (we) check("mem_dout", {24'd0, ram_dout}, (wdata >> (8 * (c - 1))) & 32'hFF);
            end else if (!mem_done) begin
                check("mem_gap_wr", {31'd0, ram_wr}, 32'd0);
            end
            if (mem_done) begin
                got = c;
                check("mem_stall_done", {31'd0, mem_stall}, 32'd0);
                mem_req = 1'b0;
            end
        end
        mem_req = 1'b0;
        check("mem_lat", got, lat);
        check("mem_rdata", mem_rdata, exp);
        check("mem_if_hold", if_data, last_if);
        last_rd = exp;
    endtask

    task automatic do_both(input logic [31:0] maddr, input logic [1:0] msize, input logic [31:0] faddr);
        int          n;
        int          md;
        int          fd;
        int          flat;
        logic [31:0] mexp;
        logic [31:0] fexp;
        logic        hit;
        n    = (msize == 2'b00) ? 1 : (msize == 2'b01) ? 2 : 4;
        mexp = '0;
        for (int i = 0; i < n; i++) mexp |= {24'd0, ref_rd(maddr + i)} << (8 * i);
        hit  = IBUF && ib_v && (ib_tag == faddr[31:2]);
        flat = hit ? 1 : 6;
        fexp = hit ? ib_data : {ref_rd(faddr + 3), ref_rd(faddr + 2), ref_rd(faddr + 1), ref_rd(faddr)};
        @(posedge clk); @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_size = msize; mem_addr = maddr; mem_wdata = '0;
        if_req  = 1'b1; if_addr = faddr;
        md = 0;
        fd = 0;
        for (int c = 1; c <= 40 && fd == 0; c++) begin
            @(posedge clk); #1;
            if (!if_done) check("both_if_stall", {31'd0, if_stall}, 32'd1);
            if (mem_done && md == 0) begin
                md = c;
                check("both_mem_data", mem_rdata, mexp);
                mem_req = 1'b0;
            end
            if (if_done) begin
                fd = c;
                check("both_if_data", if_data, fexp);
                if_req = 1'b0;
            end
        end
        mem_req = 1'b0;
        if_req  = 1'b0;
        check("both_mem_lat", md, n + 2);
        check("both_if_lat", fd, n + 2 + flat);
        last_rd = mexp;
        last_if = fexp;
        ib_v    = 1'b1;
        ib_tag  = faddr[31:2];
        ib_data = fexp;
    endtask

    initial begin
        logic        seen_done;
        logic [31:0] a;
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_size = '0; mem_addr = '0; mem_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_if_data", if_data, 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        check("rst_dones", {30'd0, if_done, mem_done}, 32'd0);
        check("rst_ram_a", ram_a, 32'd0);
        check("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
        check("rst_dout", {24'd0, ram_dout}, 32'd0);
        rst_n = 1'b1;

        set_byte(32'h100, 8'h13); set_byte(32'h101, 8'h00);
        set_byte(32'h102, 8'h50); set_byte(32'h103, 8'h00);
        do_fetch(32'h100);
        check("fetch_0x100", if_data, 32'h0050_0013);

        do_mem(1'b1, 2'b10, 32'h20, 32'hDEAD_BEEF);
        do_mem(1'b0, 2'b10, 32'h20, 32'h0);
        check("store_readback", mem_rdata, 32'hDEAD_BEEF);

        set_byte(32'h31, 8'h34); set_byte(32'h32, 8'h12);
        do_mem(1'b0, 2'b01, 32'h31, 32'h0);
        check("load_half_0x31", mem_rdata, 32'h0000_1234);

        do_both(32'h20, 2'b10, 32'h140);

        do_fetch(32'h100);
        do_mem(1'b1, 2'b00, 32'h102, 32'h0000_00AA);
        do_fetch(32'h100);

        do_mem(1'b1, 2'b11, 32'hFFFF_FFFE, 32'h8765_4321);
        do_mem(1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0);
        check("wrap_readback", mem_rdata, 32'h8765_4321);

        // Reset in the second cycle of a word store
        @(posedge clk); @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b10; mem_addr = 32'h60; mem_wdata = 32'hA1B2_C3D4;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0; mem_req = 1'b0; if_req = 1'b1; if_addr = 32'h200;
        #1;
        check("rst_stall_comb", {31'd0, if_stall}, 32'd1);
        @(posedge clk); #1;
        check("abort_wr", {31'd0, ram_wr}, 32'd0);
        check("abort_ram_a", ram_a, 32'd0);
        check("abort_if_data", if_data, 32'd0);
        check("abort_mem_rdata", mem_rdata, 32'd0);
        if_req = 1'b0;
        rst_n  = 1'b1;
        ref_mem[32'h60] = 8'hD4;
        ref_mem[32'h61] = 8'hC3;
        ib_v    = 1'b0;
        last_if = '0;
        last_rd = '0;
        seen_done = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (mem_done) seen_done = 1'b1;
            @(posedge clk); #1;
        end
        check("abort_no_done", {31'd0, seen_done}, 32'd0);
        do_mem(1'b0, 2'b10, 32'h60, 32'h0);

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 3))
                0: do_fetch(32'h200 + 32'($urandom_range(0, 3)) * 4);
                1: do_both(32'h200 + 32'($urandom_range(0, 20)), 2'($urandom_range(0, 3)),
                           32'h200 + 32'($urandom_range(0, 3)) * 4);
                default: begin
                    a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                                    : 32'h200 + 32'($urandom_range(0, 20));
                    do_mem(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom);
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
